tlul_sram_resp: RTL and testbench
=================================

# tlul_sram_resp

TL-UL device-side responder that terminates one crossbar device port and drives a single-port synchronous SRAM macro. It sits behind the RAM arbitration socket: it accepts A-channel Get, PutFullData and PutPartialData requests, issues them to the SRAM, and returns D-channel AccessAck/AccessAckData responses. It has a 1-cycle pipeline and a 2-entry response buffer, and sustains one request per cycle under continuous d_ready.

## Interface
- Depth, 2048: SRAM size in 32-bit words; need not be a power of two.
- AW, $clog2(Depth): SRAM word-address width (derived).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- tl_i  in  tlul_pkg::tl_h2d_t  A-channel request plus d_ready.
- tl_o  out  tlul_pkg::tl_d2h_t  D-channel response plus a_ready.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  AW  word address, taken from a_address[AW+1:2].
- mem_wdata_o  out  32  a_data.
- mem_wmask_o  out  32  bit mask; byte i = {8{a_mask[i]}}.
- mem_rdata_i  in  32  read data, valid the cycle after mem_req_o & ~mem_we_o.

## Operation
- Accept: a request is accepted when a_valid & a_ready.
- Error: an accepted request is flagged err when any of the following holds:
  - opcode is not in {Get=4, PutFull=0, PutPartial=1};
  - a_size > 2;
  - a_address is not aligned to 2^a_size;
  - word index a_address[31:2] ≥ Depth.
- SRAM strobe: mem_req_o = accept & ~err. It is combinational and asserted in the accept cycle. mem_we_o = (opcode != Get). For Get, the mask is ignored.
- Errored requests never touch the SRAM.
- Stage S1 registers {valid, is_get, err, size, source} on accept.
- Response construction from S1:
  - d_opcode = AccessAckData(1) if is_get, else AccessAck(0).
  - d_size and d_source are echoed from the request.
  - d_error = err.
  - d_data = mem_rdata_i for a good Get, 32'hFFFF_FFFF for an errored Get, 0 for Put.
  - d_param, d_sink and the remaining D fields are 0.
- Response FIFO holds 2 entries; head is the oldest response.
- D output: if the FIFO is non-empty, the head is presented; otherwise S1 is presented directly (bypass).
- S1 is pushed into the FIFO only if it is not consumed by the D handshake that cycle.
- Ordering: responses are returned strictly in acceptance order.
- Credit: cnt = fifo_count + S1.valid, registered. a_ready = ~rst_i & (cnt < 2).
  - a_ready has no combinational path from a_valid or d_ready.
- Reset:
  - S1, the FIFO and cnt are cleared.
  - Responses in flight when reset asserts are discarded.
  - The SRAM contents are untouched.

## Timing
- Reset values, while rst_i is high and in the cycle after it falls:
  - while rst_i is high: a_ready = 0;
  - d_valid = 0 and mem_req_o = 0;
  - all D fields = 0 except d_data, which may be X only when d_valid = 0.
- Latency: a request accepted in cycle N gives d_valid in N+1 when nothing is buffered ahead of it.
- Throughput: with d_ready held at 1, a_ready stays at 1 and one transaction completes per cycle.
- Backpressure: with d_ready = 0, two requests are accepted, then a_ready = 0 from the 3rd cycle. a_ready returns to 1 the cycle after a D handshake frees a slot.
- Handshake stability: once asserted, d_valid and every D field hold stable until d_ready.
- Simultaneous events: in the same cycle, a FIFO pop, an S1 push and a new accept must all be handled. cnt is updated as cnt + accept − d_handshake.
- Full FIFO with S1 valid: cannot occur by construction. The bench must assert cnt ≤ 2 and that no push happens when the FIFO is full.

## Test plan
- Write then read, d_ready = 1:
  - stimulus: PutFull at addr 0x10, data 0xDEADBEEF, mask 0xF; then Get at 0x10;
  - mem_req_o is seen at N and N+1;
  - responses: AccessAck, d_error = 0 at N+1, then AccessAckData with d_data = 0xDEADBEEF at N+2.
- Partial write:
  - stimulus: PutPartial at 0x10, data 0x00AA0000, mask 0x4; then Get at 0x10;
  - mem_wmask_o = 0x00FF0000;
  - read returns 0xDEAAB EEF with the byte-2 update, i.e. 0xDEAABEEF.
- Errors:
  - stimulus: Get at 0x2002 with size 2 (misaligned); Get at Depth*4; opcode 3;
  - each gives d_error = 1 one cycle later, with no mem_req_o;
  - the two Gets return d_data = 0xFFFFFFFF; the opcode-3 request returns AccessAck.
- Backpressure:
  - stimulus: d_ready = 0 with a_valid held for 4 requests tagged source 1..4;
  - only sources 1 and 2 are accepted and a_ready drops;
  - then d_ready = 1: responses appear in order 1, 2, 3, 4, with no loss and no duplicates.
- Streaming:
  - stimulus: 16 back-to-back Gets with d_ready = 1;
  - 16 responses on consecutive cycles starting at N+1, with a_ready never 0.
- Reset mid-operation:
  - stimulus: rst_i asserted with 2 responses buffered;
  - d_valid = 0 the next cycle and no stale response ever appears;
  - after release, previously written SRAM data reads back unchanged.

Source files
------------

// File: rtl/tlul_sram_resp.sv
// tlul_sram_resp: TL-UL device responder driving a single-port synchronous SRAM,
// with a one-stage pipeline and a 2-entry response buffer.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_sram_resp #(
    parameter int Depth = 2048,
    parameter int AW    = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic [31:0]        mem_wmask_o,
    input  logic [31:0]        mem_rdata_i
);
    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic       s1_valid_q, s1_get_q, s1_err_q;
    logic [1:0] s1_size_q;
    logic [7:0] s1_source_q;
    rsp_t       fifo_q [2];
    logic       wptr_q, rptr_q;
    logic [1:0] fifo_cnt_q, cnt_q, cnt_d;
    logic       a_ready, accept, err, op_ok, misaligned, oob;
    logic       fifo_empty, d_valid, d_hs, push, pop;
    rsp_t       s1_rsp, head;
    logic       unused_param;

    assign unused_param = ^tl_i.a_param;

    assign op_ok = tl_i.a_opcode == Get || tl_i.a_opcode == PutFullData ||
                   tl_i.a_opcode == PutPartialData;
    assign misaligned = (tl_i.a_size == 2'd1 && tl_i.a_address[0]) ||
                        (tl_i.a_size == 2'd2 && |tl_i.a_address[1:0]);
    assign oob = {2'b0, tl_i.a_address[31:2]} >= 32'(Depth);
    assign err = !op_ok || tl_i.a_size == 2'd3 || misaligned || oob;

    // Credit counts everything accepted but not yet returned, so a_ready never
    // depends combinationally on a_valid or d_ready.
    assign a_ready = !rst_i && cnt_q < 2'd2;
    assign accept  = tl_i.a_valid && a_ready;

    assign mem_req_o   = accept && !err;
    assign mem_we_o    = tl_i.a_opcode != Get;
    assign mem_addr_o  = tl_i.a_address[AW+1:2];
    assign mem_wdata_o = tl_i.a_data;
    assign mem_wmask_o = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                          {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

    assign s1_rsp = '{op:     s1_get_q ? AccessAckData : AccessAck,
                      size:   s1_size_q,
                      source: s1_source_q,
                      data:   s1_get_q ? (s1_err_q ? 32'hFFFF_FFFF : mem_rdata_i) : 32'h0,
                      err:    s1_err_q};

    assign fifo_empty = fifo_cnt_q == 2'd0;
    assign head       = fifo_empty ? s1_rsp : fifo_q[rptr_q];
    assign d_valid    = !fifo_empty || s1_valid_q;
    assign d_hs       = !rst_i && d_valid && tl_i.d_ready;
    assign pop        = !fifo_empty && d_hs;
    // S1 only bypasses to D when nothing older is queued.
    assign push       = s1_valid_q && !(fifo_empty && d_hs);
    assign cnt_d      = cnt_q + {1'b0, accept} - {1'b0, d_hs};

    always_comb begin
        tl_o = '0;
        tl_o.a_ready = a_ready;
        if (!rst_i) begin
            tl_o.d_valid  = d_valid;
            tl_o.d_opcode = head.op;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_data   = head.data;
            tl_o.d_error  = head.err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_get_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_size_q   <= '0;
            s1_source_q <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            fifo_cnt_q  <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_get_q    <= tl_i.a_opcode == Get;
                s1_err_q    <= err;
                s1_size_q   <= tl_i.a_size;
                s1_source_q <= tl_i.a_source;
            end
            if (push) begin
                fifo_q[wptr_q] <= s1_rsp;
                wptr_q         <= !wptr_q;
            end
            if (pop) rptr_q <= !rptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_tlul_sram_resp.sv
// tb_tlul_sram_resp: directed vector table, hand sequences and random traffic
// checked against a transaction-level queue model of the responder.
module tb_tlul_sram_resp;
    import tlul_pkg::*;

    localparam int Depth = 2048;
    localparam int AW    = $clog2(Depth);

    logic clk = 1'b0, rst;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_wmask_o, rdata_q;

    always #5 clk = ~clk;

    tlul_sram_resp #(.Depth(Depth)) dut (
        .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(rdata_q)
    );

    logic [31:0] sram [Depth] = '{default: 32'h0};
    always @(posedge clk)
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
            else rdata_q <= sram[mem_addr_o];
        end

    typedef struct {
        logic [2:0] op; logic [1:0] size; logic [7:0] src; logic [31:0] data; logic err;
    } rsp_t;

    typedef struct {
        logic [2:0] op; logic [1:0] sz; logic [31:0] addr; logic [31:0] data; logic [3:0] mask;
        logic [7:0] src; logic e_req; logic [31:0] e_wmask; logic [2:0] e_dop; logic e_err; logic [31:0] e_data;
    } vec_t;

    logic [31:0] mem_m [Depth] = '{default: 32'h0};
    rsp_t exp_q[$];
    int tests = 0, fails = 0;
    logic obs_req, obs_hs, obs_acc;
    logic [31:0] obs_wmask;
    rsp_t obs_rsp;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_err(logic [2:0] op, logic [1:0] sz, logic [31:0] a);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1;
        if (sz > 2) return 1;
        if (a % (32'd1 << sz) != 0) return 1;
        if ((a >> 2) >= Depth) return 1;
        return 0;
    endfunction

    // Called just after a negedge with inputs set; checks, updates the model
    // with this cycle's handshakes, then waits for the next negedge.
    task automatic tick();
        rsp_t r;
        bit e;
        int idx;
        logic [31:0] wm;
        #1;
        obs_hs = 0; obs_acc = 0;
        obs_req = mem_req_o; obs_wmask = mem_wmask_o;
        chk("cnt_le2", 32'(dut.cnt_q <= 2), 1);
        chk("no_push_full", 32'(dut.push && dut.fifo_cnt_q == 2), 0);
        if (rst) begin
            chk("rst_a_ready", tl_o.a_ready, 0);
            chk("rst_d_valid", tl_o.d_valid, 0);
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_d_fields", {tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source, tl_o.d_sink, tl_o.d_error}, 0);
            exp_q.delete();
        end else begin
            chk("a_ready", tl_o.a_ready, 32'(exp_q.size() < 2));
            chk("d_valid", tl_o.d_valid, 32'(exp_q.size() > 0));
            if (tl_o.d_valid && exp_q.size() > 0) begin
                r = exp_q[0];
                chk("d_opcode", tl_o.d_opcode, r.op);
                chk("d_size", tl_o.d_size, r.size);
                chk("d_source", tl_o.d_source, r.src);
                chk("d_data", tl_o.d_data, r.data);
                chk("d_error", tl_o.d_error, r.err);
                chk("d_param_sink", {tl_o.d_param, tl_o.d_sink}, 0);
                obs_rsp = '{tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error};
                if (tl_i.d_ready) begin
                    void'(exp_q.pop_front());
                    obs_hs = 1;
                end
            end
            if (tl_i.a_valid && tl_o.a_ready) begin
                obs_acc = 1;
                e = m_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address);
                idx = int'(tl_i.a_address[31:2]);
                chk("mem_req", mem_req_o, 32'(!e));
                for (int i = 0; i < 4; i++) wm[8*i +: 8] = {8{tl_i.a_mask[i]}};
                if (!e) begin
                    chk("mem_we", mem_we_o, 32'(tl_i.a_opcode != 3'd4));
                    chk("mem_addr", 32'(mem_addr_o), idx);
                    if (tl_i.a_opcode != 3'd4) begin
                        chk("mem_wdata", mem_wdata_o, tl_i.a_data);
                        chk("mem_wmask", mem_wmask_o, wm);
                    end
                end
                r.op = tl_i.a_opcode == 3'd4 ? 3'd1 : 3'd0;
                r.size = tl_i.a_size;
                r.src = tl_i.a_source;
                r.err = e;
                r.data = tl_i.a_opcode != 3'd4 ? 32'h0 : e ? 32'hFFFF_FFFF : mem_m[idx];
                if (!e && tl_i.a_opcode != 3'd4) mem_m[idx] = (mem_m[idx] & ~wm) | (tl_i.a_data & wm);
                exp_q.push_back(r);
            end else begin
                chk("mem_req_idle", mem_req_o, 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(logic [2:0] op, logic [1:0] sz, logic [31:0] a, logic [31:0] d, logic [3:0] m, logic [7:0] s);
        tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_size = sz; tl_i.a_address = a;
        tl_i.a_data = d; tl_i.a_mask = m; tl_i.a_source = s;
    endtask

    vec_t vecs[13];
    int acc, gaps, drops, stale, r;
    logic [7:0] got[$];

    initial begin
        vecs[0]  = '{3'd0, 2'd2, 32'h10,   32'hDEADBEEF, 4'hF, 8'd1,  1'b1, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{3'd4, 2'd2, 32'h10,   32'h0,        4'hF, 8'd2,  1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{3'd1, 2'd2, 32'h10,   32'h00AA0000, 4'h4, 8'd3,  1'b1, 32'h00FF0000, 3'd0, 1'b0, 32'h0};
        vecs[3]  = '{3'd4, 2'd2, 32'h10,   32'h0,        4'hF, 8'd4,  1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'hDEAABEEF};
        vecs[4]  = '{3'd4, 2'd2, 32'h2002, 32'h0,        4'hF, 8'd5,  1'b0, 32'h0,        3'd1, 1'b1, 32'hFFFFFFFF};
        vecs[5]  = '{3'd4, 2'd2, 32'h2000, 32'h0,        4'hF, 8'd6,  1'b0, 32'h0,        3'd1, 1'b1, 32'hFFFFFFFF};
        vecs[6]  = '{3'd3, 2'd2, 32'h10,   32'h0,        4'hF, 8'd7,  1'b0, 32'h0,        3'd0, 1'b1, 32'h0};
        vecs[7]  = '{3'd4, 2'd3, 32'h0,    32'h0,        4'hF, 8'd8,  1'b0, 32'h0,        3'd1, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{3'd4, 2'd1, 32'h11,   32'h0,        4'hF, 8'd9,  1'b0, 32'h0,        3'd1, 1'b1, 32'hFFFFFFFF};
        vecs[9]  = '{3'd4, 2'd0, 32'h13,   32'h0,        4'hF, 8'd10, 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'hDEAABEEF};
        vecs[10] = '{3'd4, 2'd2, 32'h1FFC, 32'h0,        4'hF, 8'd11, 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h0};
        vecs[11] = '{3'd0, 2'd1, 32'h12,   32'h12340000, 4'hC, 8'd12, 1'b1, 32'hFFFF0000, 3'd0, 1'b0, 32'h0};
        vecs[12] = '{3'd4, 2'd2, 32'h10,   32'h0,        4'hF, 8'd13, 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h1234BEEF};

        tl_i = '0;
        rst = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_rst_a_ready", tl_o.a_ready, 1);

        tl_i.d_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].sz, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].src);
            tick();
            chk("tbl_acc", obs_acc, 1);
            chk("tbl_req", obs_req, vecs[i].e_req);
            if (vecs[i].e_req) chk("tbl_wmask", obs_wmask, vecs[i].e_wmask);
            tl_i.a_valid = 1'b0;
            tick();
            chk("tbl_latency", obs_hs, 1);
            chk("tbl_dop", obs_rsp.op, vecs[i].e_dop);
            chk("tbl_err", obs_rsp.err, vecs[i].e_err);
            chk("tbl_data", obs_rsp.data, vecs[i].e_data);
            chk("tbl_src", obs_rsp.src, vecs[i].src);
            chk("tbl_size", obs_rsp.size, vecs[i].sz);
        end

        // Backpressure: only two requests fit while d_ready is low.
        tl_i.d_ready = 1'b0;
        acc = 0;
        drive(3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (obs_acc) begin acc++; tl_i.a_source = 8'(acc + 1); end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_a_ready_low", tl_o.a_ready, 0);
        tl_i.d_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            tick();
            if (obs_acc) begin
                acc++;
                if (acc < 4) tl_i.a_source = 8'(acc + 1); else tl_i.a_valid = 1'b0;
            end
            if (obs_hs) got.push_back(obs_rsp.src);
        end
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], i + 1);
        tl_i.a_valid = 1'b0;
        repeat (3) tick();

        // Streaming: 16 back-to-back Gets, one response per cycle.
        gaps = 0; drops = 0;
        for (int i = 0; i < 16; i++) begin
            drive(3'd4, 2'd2, 32'(i * 4), 32'h0, 4'hF, 8'(8'h40 + i));
            if (!tl_o.a_ready) drops++;
            tick();
            if (!obs_acc) drops++;
            if (i > 0 && !obs_hs) gaps++;
        end
        tl_i.a_valid = 1'b0;
        tick();
        if (!obs_hs) gaps++;
        chk("stream_a_ready", drops, 0);
        chk("stream_gaps", gaps, 0);

        // Reset with two responses buffered.
        tl_i.d_ready = 1'b0;
        drive(3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h70);
        tick();
        tl_i.a_source = 8'h71; tl_i.a_address = 32'h14;
        tick();
        tl_i.a_valid = 1'b0;
        tick();
        chk("rst_pre_dvalid", tl_o.d_valid, 1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tl_i.d_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            tick();
            if (tl_o.d_valid) stale++;
        end
        chk("rst_no_stale", stale, 0);
        drive(3'd4, 2'd2, 32'h10, 32'h0, 4'hF, 8'h72);
        tick();
        tl_i.a_valid = 1'b0;
        tick();
        chk("rst_readback_hs", obs_hs, 1);
        chk("rst_readback", obs_rsp.data, 32'h1234BEEF);

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            tl_i.a_opcode = r < 4 ? 3'd4 : r < 6 ? 3'd0 : r < 8 ? 3'd1 : r == 8 ? 3'd3 : 3'($urandom_range(5, 7));
            tl_i.a_address = 32'((($urandom_range(0, 19) == 0) ? Depth - 2 + $urandom_range(0, 3) : $urandom_range(0, 15)) * 4);
            if ($urandom_range(0, 3) == 0) tl_i.a_address[1:0] = 2'($urandom_range(0, 3));
            tl_i.a_size = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            tl_i.a_data = $urandom;
            tl_i.a_mask = 4'($urandom_range(0, 15));
            tl_i.a_source = 8'($urandom_range(0, 255));
            tl_i.a_valid = $urandom_range(0, 3) != 0;
            tl_i.d_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        repeat (6) tick();
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
